clb_column_pipe: RTL and testbench

- Parametrised, pipelined successor to the 4-cell combinational CLB column.
- Holds CELLS identical ALU/shift cells. Each cell selects two of 8 WIDTH-bit inputs, applies a 3-bit op or bypass, and returns a registered result.
- Config is double-buffered: shadow registers are written per cell, then committed atomically.
- Data moves through a 2-stage valid/ready pipeline. It sits between the CLB input crossbar and the next column.

---
 rtl/clb_column_pipe.sv | 239 +++++++++++++++++++++++
 tb/tb_clb_column_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/clb_column_pipe.sv
// clb_column_pipe: CELLS ALU/shift cells with double-buffered config; optional CLB_SAT_EN makes add/sub signed-saturating with sat_flag.
// Latency: 2 cycles from in_valid&in_ready to out_valid (operand mux stage, execute stage); 1 result per cycle.
// Backpressure: out_ready=0 holds out_bus/out_valid; stage 1 then fills and in_ready drops (never combinational on in_valid).
module clb_column_pipe #(
  parameter int WIDTH = 32,
  parameter int CELLS = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*WIDTH-1:0]     in_bus,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [CELLS*WIDTH-1:0] out_bus,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   cfg_wr,
  input  logic [3:0]             cfg_addr,
  input  logic [9:0]             cfg_data,
  input  logic                   cfg_commit,
  output logic                   cfg_err
`ifdef CLB_SAT_EN
  ,
  output logic [CELLS-1:0]       sat_flag
`endif
);

  typedef struct packed {
    logic       bypass;
    logic [2:0] sel0;
    logic [2:0] sel1;
    logic [2:0] op;
  } cfg_t;

`ifdef CLB_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // Reset config: every cell bypasses input c%8 so the column is a plain passthrough.
  function automatic cfg_t cfg_rst(input int c);
    cfg_t r;
    r.bypass = 1'b1;
    r.sel0   = 3'(c % 8);
    r.sel1   = 3'd0;
    r.op     = 3'd0;
    return r;
  endfunction

`ifdef CLB_SAT_EN
  // Signed overflow of the add/sub ops; other ops never saturate.
  function automatic logic cell_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic [2:0] op, input logic byp);
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic             ovf;
    sum = a + b;
    dif = a - b;
    ovf = 1'b0;
    if (!byp && op == 3'b000)
      ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    else if (!byp && op == 3'b001)
      ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
    return ovf;
  endfunction
`endif

  // One cell's execute function; shift amount uses only the low SHW bits of b.
  function automatic logic [WIDTH-1:0] cell_exec(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic [2:0] op, input logic byp);
    logic [WIDTH-1:0] r;
    logic [SHW-1:0]   sh;
    sh = b[SHW-1:0];
    r  = a;
    if (!byp) begin
      case (op)
        3'b000:  r = a + b;
        3'b001:  r = a - b;
        3'b010:  r = a & b;
        3'b011:  r = a | b;
        3'b100:  r = a ^ b;
        3'b101:  r = a << sh;
        3'b110:  r = a >> sh;
        default: r = $unsigned($signed(a) >>> sh);
      endcase
    end
`ifdef CLB_SAT_EN
    // Clamp toward the sign of a: overflow only happens when a carries the dominant sign.
    if (cell_ovf(a, b, op, byp))
      r = a[WIDTH-1] ? SMIN : SMAX;
`endif
    return r;
  endfunction

  cfg_t shadow_q [CELLS];
  cfg_t shadow_d [CELLS];
  cfg_t active_q [CELLS];
  cfg_t active_d [CELLS];
  logic cfg_err_q, cfg_err_d;
  logic cfg_oor;

  logic [WIDTH-1:0] in_arr   [8];
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q   [CELLS];
  logic [WIDTH-1:0] s1_a_d   [CELLS];
  logic [WIDTH-1:0] s1_b_q   [CELLS];
  logic [WIDTH-1:0] s1_b_d   [CELLS];
  logic [2:0]       s1_op_q  [CELLS];
  logic [2:0]       s1_op_d  [CELLS];
  logic [CELLS-1:0] s1_byp_q, s1_byp_d;

  logic                   out_valid_q, out_valid_d;
  logic [CELLS*WIDTH-1:0] out_bus_q, out_bus_d;
`ifdef CLB_SAT_EN
  logic [CELLS-1:0]       sat_q, sat_d;
`endif

  logic s1_advance;
  logic accept;

  // Unpack the eight operand lanes.
  always_comb begin
    for (int k = 0; k < 8; k++)
      in_arr[k] = in_bus[k*WIDTH +: WIDTH];
  end

  // Shadow writes and atomic commit; a same-cycle write is folded into the commit.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    cfg_oor  = ({1'b0, cfg_addr} >= 5'(CELLS));
    for (int c = 0; c < CELLS; c++) begin
      if (cfg_wr && (cfg_addr == 4'(c)))
        shadow_d[c] = cfg_t'(cfg_data);
    end
    if (cfg_commit)
      active_d = shadow_d;
    cfg_err_d = cfg_err_q | (cfg_wr & cfg_oor);
  end

  // Config state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CELLS; c++) begin
        shadow_q[c] <= cfg_rst(c);
        active_q[c] <= cfg_rst(c);
      end
      cfg_err_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Handshake: stage 1 moves on whenever stage 2 is empty or draining this cycle.
  always_comb begin
    s1_advance = s1_valid_q & (~out_valid_q | out_ready);
    in_ready   = ~s1_valid_q | s1_advance;
    accept     = in_valid & in_ready;
  end

  // Stage 1: operand mux, capturing the active config alongside the data.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_byp_d   = s1_byp_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      for (int c = 0; c < CELLS; c++) begin
        s1_a_d[c]   = in_arr[active_q[c].sel0];
        s1_b_d[c]   = in_arr[active_q[c].sel1];
        s1_op_d[c]  = active_q[c].op;
        s1_byp_d[c] = active_q[c].bypass;
      end
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2: execute and register results; held while downstream stalls.
  always_comb begin
    out_valid_d = out_valid_q;
    out_bus_d   = out_bus_q;
`ifdef CLB_SAT_EN
    sat_d       = sat_q;
`endif
    if (s1_advance) begin
      out_valid_d = 1'b1;
      for (int c = 0; c < CELLS; c++) begin
        out_bus_d[c*WIDTH +: WIDTH] = cell_exec(s1_a_q[c], s1_b_q[c], s1_op_q[c], s1_byp_q[c]);
`ifdef CLB_SAT_EN
        sat_d[c] = cell_ovf(s1_a_q[c], s1_b_q[c], s1_op_q[c], s1_byp_q[c]);
`endif
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Pipeline state registers; reset drops anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_byp_q    <= '0;
      for (int c = 0; c < CELLS; c++) begin
        s1_a_q[c]  <= '0;
        s1_b_q[c]  <= '0;
        s1_op_q[c] <= '0;
      end
      out_valid_q <= 1'b0;
      out_bus_q   <= '0;
`ifdef CLB_SAT_EN
      sat_q       <= '0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      s1_byp_q    <= s1_byp_d;
      out_valid_q <= out_valid_d;
      out_bus_q   <= out_bus_d;
`ifdef CLB_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign out_bus   = out_bus_q;
  assign out_valid = out_valid_q;
  assign cfg_err   = cfg_err_q;
`ifdef CLB_SAT_EN
  assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_clb_column_pipe.sv
// Directed bench for clb_column_pipe (WIDTH=32, CELLS=4); optional CLB_SAT_EN section.
// Inputs driven on the falling edge, outputs sampled shortly after it.
// Every check is an immediate assertion against hand-computed constants.
module tb_clb_column_pipe;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] in_bus = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] out_bus;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         cfg_wr = 1'b0;
  logic [3:0]   cfg_addr = '0;
  logic [9:0]   cfg_data = '0;
  logic         cfg_commit = 1'b0;
  logic         cfg_err;
`ifdef CLB_SAT_EN
  logic [3:0]   sat_flag;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [127:0] r;
  int           lat;
  logic [31:0]  exp_ops [8] = '{32'h000100E7, 32'h0000E0FF, 32'h000000F0, 32'h0000FFF7,
                               32'h0000FF07, 32'h0F300000, 32'h00000000, 32'h00000000};

  clb_column_pipe #(.WIDTH(32), .CELLS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_bus(in_bus), .in_valid(in_valid), .in_ready(in_ready),
    .out_bus(out_bus), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_err(cfg_err)
`ifdef CLB_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int k, input logic [31:0] v);
    in_bus[k*32 +: 32] = v;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [9:0] d, input logic commit);
    @(negedge clk);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = d; cfg_commit = commit;
    @(negedge clk);
    cfg_wr = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic commit_only();
    @(negedge clk);
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
  endtask

  // One transfer into an empty pipe; latency counted in falling edges after acceptance (0 = timed out).
  task automatic send(output logic [127:0] res, output int l);
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    l = 0;
    res = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (out_valid) begin
        l = i;
        res = out_bus;
        break;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) set_in(k, 32'h1000 + k);

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_out_bus", out_bus, 128'h0);
    chk("rst_out_valid", {127'h0, out_valid}, 128'h0);
    chk("rst_cfg_err", {127'h0, cfg_err}, 128'h0);
    chk("rst_in_ready", {127'h0, in_ready}, 128'h1);
`ifdef CLB_SAT_EN
    chk("rst_sat_flag", {124'h0, sat_flag}, 128'h0);
`endif
    rst_n = 1'b1;

    // Reset config passes input c through to cell c
    send(r, lat);
    chk("pass_lat", 128'(lat), 128'd2);
    chk("pass_bus", r, {32'h1003, 32'h1002, 32'h1001, 32'h1000});

    // Cell1 = in2 - in5, written then committed in a separate cycle
    cfg_write(4'd1, 10'b0_010_101_001, 1'b0);
    commit_only();
    set_in(2, 32'd10); set_in(5, 32'd3);
    send(r, lat);
    chk("sub_7", r, {32'h1003, 32'h0000000A, 32'h00000007, 32'h1000});
    set_in(2, 32'd0); set_in(5, 32'd1);
    send(r, lat);
    chk("sub_wrap", r, {32'h1003, 32'h00000000, 32'hFFFFFFFF, 32'h1000});

    // Cell3 shifts, config written and committed in the same cycle
    set_in(6, 32'h80000000); set_in(7, 32'd4);
    cfg_write(4'd3, 10'b0_110_111_111, 1'b1);
    send(r, lat);
    chk("sra", {96'h0, r[127:96]}, 128'hF8000000);
    cfg_write(4'd3, 10'b0_110_111_110, 1'b1);
    send(r, lat);
    chk("srl", {96'h0, r[127:96]}, 128'h08000000);

    // Cell0 through every op with a = 0xF0F3, b = 0x0FF4
    set_in(0, 32'h0000F0F3); set_in(1, 32'h00000FF4);
    for (int op = 0; op < 8; op++) begin
      cfg_write(4'd0, {1'b0, 3'd0, 3'd1, 3'(op)}, 1'b1);
      send(r, lat);
      chk($sformatf("op%0d", op), {96'h0, r[31:0]}, {96'h0, exp_ops[op]});
    end

    // Reset with both stages full drops data and restores the passthrough config
    for (int k = 0; k < 8; k++) set_in(k, 32'h1000 + k);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 chk("full_before_rst", {127'h0, out_valid}, 128'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {127'h0, out_valid}, 128'h0);
    chk("midrst_bus", out_bus, 128'h0);
    chk("midrst_ready", {127'h0, in_ready}, 128'h1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    send(r, lat);
    chk("midrst_cfg", r, {32'h1003, 32'h1002, 32'h1001, 32'h1000});

    // Backpressure: two accepted, third stalls, outputs stable then drain in order
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; set_in(0, 32'hA0);
    #1 chk("bp_rdy_t0", {127'h0, in_ready}, 128'h1);
    @(negedge clk);
    set_in(0, 32'hA1);
    #1 chk("bp_rdy_t1", {127'h0, in_ready}, 128'h1);
    @(negedge clk);
    set_in(0, 32'hA2);
    #1;
    chk("bp_rdy_t2", {127'h0, in_ready}, 128'h0);
    chk("bp_valid", {127'h0, out_valid}, 128'h1);
    chk("bp_bus", out_bus, {32'h1003, 32'h1002, 32'h1001, 32'hA0});
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("bp_hold_rdy", {127'h0, in_ready}, 128'h0);
      chk("bp_hold_valid", {127'h0, out_valid}, 128'h1);
      chk("bp_hold_bus", out_bus, {32'h1003, 32'h1002, 32'h1001, 32'hA0});
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("drain0", {95'h0, out_valid, out_bus[31:0]}, {95'h0, 1'b1, 32'hA0});
    chk("drain_rdy", {127'h0, in_ready}, 128'h1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("drain1", {95'h0, out_valid, out_bus[31:0]}, {95'h0, 1'b1, 32'hA1});
    @(negedge clk);
    #1 chk("drain2", {95'h0, out_valid, out_bus[31:0]}, {95'h0, 1'b1, 32'hA2});
    @(negedge clk);
    #1 chk("drain_done", {127'h0, out_valid}, 128'h0);

    // Data accepted in the commit cycle uses the old config, the next uses the new
    cfg_write(4'd2, 10'b0_010_011_000, 1'b0);
    set_in(2, 32'h100); set_in(3, 32'h23);
    in_valid = 1'b1; cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("commit_old", {95'h0, out_valid, out_bus[95:64]}, {95'h0, 1'b1, 32'h100});
    @(negedge clk);
    #1 chk("commit_new", {95'h0, out_valid, out_bus[95:64]}, {95'h0, 1'b1, 32'h123});

    // Out-of-range write: sticky error, nothing else changes
    @(negedge clk);
    cfg_wr = 1'b1; cfg_addr = 4'd4; cfg_data = 10'h000;
    @(negedge clk);
    cfg_wr = 1'b0;
    #1;
    chk("oor_err", {127'h0, cfg_err}, 128'h1);
    chk("oor_valid", {127'h0, out_valid}, 128'h0);
    chk("oor_bus", out_bus, {32'h23, 32'h123, 32'h1001, 32'hA2});
    @(negedge clk);
    #1 chk("oor_sticky", {127'h0, cfg_err}, 128'h1);
    commit_only();
    send(r, lat);
    chk("oor_cfg_kept", r, {32'h23, 32'h123, 32'h1001, 32'hA2});
    chk("oor_lat", 128'(lat), 128'd2);

    // Signed overflow on add: clamps with the saturating build, wraps otherwise
    set_in(0, 32'h7FFFFFFF); set_in(1, 32'h1);
    cfg_write(4'd0, 10'b0_000_001_000, 1'b1);
    send(r, lat);
`ifdef CLB_SAT_EN
    chk("sat_add", {96'h0, r[31:0]}, 128'h7FFFFFFF);
    chk("sat_flag", {127'h0, sat_flag[0]}, 128'h1);
`else
    chk("wrap_add", {96'h0, r[31:0]}, 128'h80000000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
